// File: rtl/mesm6_mem_arbiter.sv
`timescale 1ns/1ps
// mesm6_mem_arbiter
//
// Merges the MESM-6 core's instruction-fetch bus (ibus) and data bus (dbus)
// onto one single-port, variable-latency word memory. Data writes win over
// data reads, and data reads win over instruction fetches. Address 0 can be
// trapped so that it reads as zero and drops writes. Every wait on the memory
// is bounded by TIMEOUT cycles. After a timeout, reads return all-ones and a
// sticky bus_error is raised.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   ibus_fetch/addr       level fetch request and word address (held until done)
//   ibus_input/done       fetched word (held) and one-cycle completion pulse
//   dbus_read/write/addr  level data request and word address
//   dbus_output           write data from the core
//   dbus_input/done       read data (held) and one-cycle completion pulse
//   mem_req/we/addr/wdata registered memory request, held until mem_ready
//   mem_rdata/ready       memory read data, valid in the mem_ready cycle
//   bus_error             sticky timeout flag, cleared only by reset
module mesm6_mem_arbiter #(
    parameter int unsigned TIMEOUT        = 1023,
    parameter bit          ZERO_ADDR_TRAP = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ibus_fetch,
    input  logic [14:0] ibus_addr,
    output logic [47:0] ibus_input,
    output logic        ibus_done,
    input  logic        dbus_read,
    input  logic        dbus_write,
    input  logic [14:0] dbus_addr,
    input  logic [47:0] dbus_output,
    output logic [47:0] dbus_input,
    output logic        dbus_done,
    output logic        mem_req,
    output logic        mem_we,
    output logic [14:0] mem_addr,
    output logic [47:0] mem_wdata,
    input  logic [47:0] mem_rdata,
    input  logic        mem_ready,
    output logic        bus_error
);
    typedef enum logic [1:0] {S_IDLE, S_MEM, S_DONE, S_RECOVER} state_t;

    // Count value of the last MEM cycle that may still wait for mem_ready.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [14:0] mem_addr_q, mem_addr_d;
    logic [47:0] mem_wdata_q, mem_wdata_d;
    logic [47:0] ibus_input_q, ibus_input_d;
    logic [47:0] dbus_input_q, dbus_input_d;
    logic        ibus_done_q, ibus_done_d;
    logic        dbus_done_q, dbus_done_d;
    logic        bus_error_q, bus_error_d;
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic        port_dbus_q, port_dbus_d;   // 1: the latched transaction belongs to dbus

    logic        win_dbus;
    logic        win_we;
    logic [14:0] win_addr;
    logic        trap;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            ibus_input_q <= '0;
            dbus_input_q <= '0;
            ibus_done_q  <= 1'b0;
            dbus_done_q  <= 1'b0;
            bus_error_q  <= 1'b0;
            tmo_cnt_q    <= '0;
            port_dbus_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            ibus_input_q <= ibus_input_d;
            dbus_input_q <= dbus_input_d;
            ibus_done_q  <= ibus_done_d;
            dbus_done_q  <= dbus_done_d;
            bus_error_q  <= bus_error_d;
            tmo_cnt_q    <= tmo_cnt_d;
            port_dbus_q  <= port_dbus_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        ibus_input_d = ibus_input_q;
        dbus_input_d = dbus_input_q;
        ibus_done_d  = 1'b0;
        dbus_done_d  = 1'b0;
        bus_error_d  = bus_error_q;
        tmo_cnt_d    = tmo_cnt_q;
        port_dbus_d  = port_dbus_q;

        // A simultaneous read and write on dbus performs the write only.
        win_dbus = dbus_write | dbus_read;
        win_we   = dbus_write;
        win_addr = win_dbus ? dbus_addr : ibus_addr;
        trap     = ZERO_ADDR_TRAP && (win_addr == 15'd0);

        case (state_q)
            S_IDLE: begin
                if (win_dbus || ibus_fetch) begin
                    port_dbus_d = win_dbus;
                    if (trap) begin
                        // Served internally: read data is ready for the DONE cycle.
                        state_d     = S_DONE;
                        ibus_done_d = !win_dbus;
                        dbus_done_d = win_dbus;
                        if (!win_we) begin
                            if (win_dbus) dbus_input_d = '0;
                            else          ibus_input_d = '0;
                        end
                    end else begin
                        state_d     = S_MEM;
                        mem_req_d   = 1'b1;
                        mem_we_d    = win_we;
                        mem_addr_d  = win_addr;
                        mem_wdata_d = dbus_output;
                        tmo_cnt_d   = '0;
                    end
                end
            end
            S_MEM: begin
                // mem_ready takes precedence over a timeout in the same cycle.
                if (mem_ready || (tmo_cnt_q == TMO_LAST)) begin
                    state_d     = S_DONE;
                    mem_req_d   = 1'b0;
                    ibus_done_d = !port_dbus_q;
                    dbus_done_d = port_dbus_q;
                    if (!mem_ready) begin
                        tmo_cnt_d   = tmo_cnt_q + 16'd1;
                        bus_error_d = 1'b1;
                    end
                    if (!mem_we_q) begin
                        if (port_dbus_q) dbus_input_d = mem_ready ? mem_rdata : '1;
                        else             ibus_input_d = mem_ready ? mem_rdata : '1;
                    end
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
                end
            end
            S_DONE:    state_d = S_RECOVER;
            // The core still holds the completed request here; ignore it.
            S_RECOVER: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign ibus_input = ibus_input_q;
    assign dbus_input = dbus_input_q;
    assign ibus_done  = ibus_done_q;
    assign dbus_done  = dbus_done_q;
    assign bus_error  = bus_error_q;

endmodule

// File: doc/mesm6_mem_arbiter.md
Name: mesm6_mem_arbiter

Overview:
- Sits directly downstream of the MESM-6 core.
- Merges the core's instruction-fetch bus (ibus) and data bus (dbus) onto one single-port, variable-latency word memory.
- Resolves priority between the two buses and implements BESM-6 address-0 semantics: address 0 reads as zero and ignores writes.
- Returns level-held read data with a one-cycle done pulse, and bounds every memory wait with a timeout.

Parameters:
- TIMEOUT, 1023, maximum cycles spent waiting for mem_ready before forced completion (1..65535).
- ZERO_ADDR_TRAP, 1, when 1 address 0 is served internally (read 0, write dropped); when 0 it is passed to memory.

Ports:
- clk  in  1  clock; all activity on rising edge.
- reset  in  1  synchronous, active-high reset.
- ibus_fetch  in  1  core instruction-fetch request, level, held until done.
- ibus_addr  in  15  instruction word address.
- ibus_input  out  48  fetched instruction word, held until next ibus completion.
- ibus_done  out  1  one-cycle completion pulse for ibus.
- dbus_read  in  1  core data-read request, level.
- dbus_write  in  1  core data-write request, level.
- dbus_addr  in  15  data word address.
- dbus_output  in  48  write data from core.
- dbus_input  out  48  read data to core, held until next dbus read completion.
- dbus_done  out  1  one-cycle completion pulse for dbus.
- mem_req  out  1  memory request, held until mem_ready sampled.
- mem_we  out  1  1 = write, 0 = read; valid with mem_req.
- mem_addr  out  15  memory address; valid with mem_req.
- mem_wdata  out  48  memory write data; valid with mem_req.
- mem_rdata  in  48  memory read data; valid in the mem_ready cycle.
- mem_ready  in  1  memory completes the current request this cycle.
- bus_error  out  1  sticky timeout flag; cleared only by reset.

Behaviour:
- Reset values:
  - State IDLE.
  - mem_req, mem_we, ibus_done, dbus_done, bus_error = 0.
  - mem_addr, mem_wdata, ibus_input, dbus_input = 0.
  - Timeout counter = 0.
  - Reset mid-transaction abandons it; no done pulse is issued.
- All outputs are registered.
- States: IDLE, MEM, DONE, RECOVER.
- IDLE: samples requests. Priority is dbus_write > dbus_read > ibus_fetch.
  - Simultaneous dbus_write and dbus_read: write is performed, read is ignored.
  - Winning request, address nonzero (or ZERO_ADDR_TRAP=0): latch addr, we and wdata into mem_* registers; mem_req=1 next cycle; go to MEM.
  - Winning request, address 0 with ZERO_ADDR_TRAP=1: no memory access; go to DONE. A read returns 48'h0; a write is dropped.
  - No request: stay in IDLE.
- MEM:
  - mem_req stays 1 and mem_addr, mem_we and mem_wdata stay stable until mem_ready is sampled 1.
  - On mem_ready: capture mem_rdata into the winning port's input register (reads only), drop mem_req, go to DONE.
  - Timeout counter increments each MEM cycle without mem_ready.
  - When the counter reaches TIMEOUT: drop mem_req, set bus_error, load 48'hFFFF_FFFF_FFFF into the read register (reads only), go to DONE.
  - The counter clears on entry to MEM.
- DONE: the winning port's done output is 1 for exactly this cycle; its read data is already valid this cycle. Go to RECOVER.
- RECOVER:
  - One mandatory cycle in which all requests are ignored. This absorbs the core's one-cycle microcode pipeline lag, during which the completed request is still asserted.
  - Go to IDLE.
- Latency from the IDLE sample to done:
  - Nonzero address: 2 + (mem_ready wait) cycles; minimum 2, when mem_ready arrives in the first MEM cycle.
  - Zero address: 1 cycle.
- Back-to-back throughput:
  - Minimum-latency memory: one transaction per 4 cycles.
  - Zero address: one transaction per 3 cycles.
- Unused-port data registers never change. ibus_input is untouched by dbus traffic and vice versa; dbus_input is untouched by writes.
- Request changes while in MEM are ignored; the latched transaction completes.
- ibus_done and dbus_done are never both 1 in the same cycle.
- Starvation: an ibus_fetch waits while dbus requests keep winning in IDLE. This is acceptable because the core never issues ibus and dbus requests together indefinitely.

Test Plan:
- Single ibus read:
  - Stimulus: ibus_fetch, addr 15'o00100; memory returns 48'h123456789ABC with mem_ready in the first MEM cycle.
  - Required: mem_req high for 1 cycle with mem_we=0 and mem_addr=0o100; ibus_done pulses exactly 2 cycles after the IDLE sample; ibus_input=48'h123456789ABC; held afterwards.
- Priority:
  - Stimulus: ibus_fetch (addr 5) and dbus_read (addr 7) raised together.
  - Required: memory sees addr 7 first and dbus_done pulses first; after RECOVER, addr 5 is served and ibus_done follows.
- Address 0:
  - Stimulus: dbus_write to addr 0 with data 48'hFFFF, then dbus_read from addr 0.
  - Required: mem_req never asserts; each dbus_done arrives 1 cycle after its sample; dbus_input=0.
- Wait states:
  - Stimulus: dbus_write addr 0o77 with data 48'hA5A5A5A5A5A5; mem_ready delayed 5 cycles.
  - Required: mem_req, addr and data stable for all 6 cycles; dbus_done pulses once; dbus_input unchanged.
- Timeout:
  - Stimulus: TIMEOUT=8, dbus_read with mem_ready never asserted.
  - Required: mem_req drops after 8 MEM cycles; dbus_done pulses; dbus_input=48'hFFFFFFFFFFFF; bus_error=1 and stays 1 until reset.
- Reset mid-operation:
  - Stimulus: assert reset during a MEM wait.
  - Required: the next cycle shows mem_req=0, no done pulse, bus_error=0, and state IDLE; a new request afterwards is served normally.
